// File: rtl/wb_rr_arbiter_pkg.sv
// wb_rr_arbiter_pkg
// Shared definitions for the wb_rr_arbiter slice: arbitration mode
// constants, the FSM state type and an index-width helper.
// Imported by wb_rr_arbiter and arb_mask_encoder.
package wb_rr_arbiter_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_GRANTED = 1'b1
    } arb_state_t;

    // Width of an index into n items, never narrower than one bit so that
    // degenerate sizes still produce a legal vector.
    function automatic int arb_idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_mask_encoder.sv
// arb_mask_encoder
// Combinational masked priority pick. Requests inside the mask are
// preferred; when none of them are set the search wraps around to the
// full request vector. The search direction selects the lowest set bit
// (ascend=1) or the highest set bit (ascend=0).
// Ports:
//   request  in  PORTS  candidate requests
//   mask     in  PORTS  preferred subset (all zero = plain priority)
//   ascend   in  1      1: lowest index wins, 0: highest index wins
//   valid    out 1      any request present
//   index    out IW     index of the winner (0 when none)
//   onehot   out PORTS  one-hot winner (0 when none)
module arb_mask_encoder
    import wb_rr_arbiter_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int IW    = arb_idx_width(PORTS)
) (
    input  logic [PORTS-1:0] request,
    input  logic [PORTS-1:0] mask,
    input  logic             ascend,
    output logic             valid,
    output logic [IW-1:0]    index,
    output logic [PORTS-1:0] onehot
);

    logic [PORTS-1:0] masked;
    logic [PORTS-1:0] pool;

    // The scan runs opposite to the priority order so the last assignment
    // made is the winner; this keeps the loop free of break statements.
    always_comb begin
        masked = request & mask;
        pool   = (masked != '0) ? masked : request;
        valid  = |request;
        index  = '0;
        onehot = '0;
        if (ascend) begin
            for (int i = PORTS - 1; i >= 0; i--) begin
                if (pool[i]) begin
                    index = IW'(i);
                end
            end
        end else begin
            for (int i = 0; i < PORTS; i++) begin
                if (pool[i]) begin
                    index = IW'(i);
                end
            end
        end
        if (valid) begin
            onehot = PORTS'(1) << index;
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter
// Registered N-way arbiter in front of the wishbone master mux. Picks one
// requester, holds the grant until its release condition, and reports the
// grant one-hot and encoded. Fixed-priority or round-robin.
// Optional feature macro: ARB_TIMEOUT_EN adds a grant watchdog that forces
// release after TIMEOUT_CYCLES cycles and pulses timeout_o.
// Ports:
//   clk_i            in   1      clock, rising edge
//   rst_ni           in   1      asynchronous active-low reset
//   request_i        in   PORTS  per-port request level
//   acknowledge_i    in   PORTS  per-port end-of-transfer pulse
//   grant_o          out  PORTS  one-hot grant, registered
//   grant_valid_o    out  1      any grant active
//   grant_encoded_o  out  IW     index of granted port (0 when none)
//   timeout_o        out  1      one-cycle pulse on watchdog release
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int PORTS             = 4,
    parameter int ARB_ROUND_ROBIN   = 1,
    parameter int LSB_HIGH_PRIORITY = 0,
    parameter int BLOCK             = 1,
    parameter int BLOCK_ACK         = 0,
    parameter int TIMEOUT_CYCLES    = 256
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [PORTS-1:0]         request_i,
    input  logic [PORTS-1:0]         acknowledge_i,
    output logic [PORTS-1:0]         grant_o,
    output logic                     grant_valid_o,
    output logic [$clog2(PORTS)-1:0] grant_encoded_o,
    output logic                     timeout_o
);

    localparam int IW = $clog2(PORTS);
    localparam logic [IW-1:0] PTR_RESET = (LSB_HIGH_PRIORITY != 0) ? IW'(PORTS - 1) : '0;

    arb_state_t       state_q, state_d;
    logic [PORTS-1:0] grant_q, grant_d;
    logic [IW-1:0]    enc_q, enc_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic             timeout_q, timeout_d;
    logic             load_grant;

    logic             release_cond;
    logic             wd_expire;
    logic [PORTS-1:0] others;
    logic [PORTS-1:0] arb_req;
    logic [PORTS-1:0] rr_mask;
    logic             pick_valid;
    logic [IW-1:0]    pick_idx;
    logic [PORTS-1:0] pick_onehot;

    // Release condition of the current holder. With BLOCK=0 the arbiter
    // re-arbitrates every cycle; otherwise the holder keeps the bus until it
    // drops its request or, in ack mode, acknowledges the transfer.
    always_comb begin
        release_cond = 1'b1;
        if (BLOCK != 0) begin
            if (BLOCK_ACK != 0) begin
                release_cond = acknowledge_i[enc_q] | ~request_i[enc_q];
            end else begin
                release_cond = ~request_i[enc_q];
            end
        end
    end

    // The current holder is only eligible again when nobody else is asking.
    // In idle grant_q is zero so this reduces to the raw request vector.
    // The round-robin mask keeps the ports strictly after the last grant in
    // search direction; fixed priority leaves the mask empty.
    always_comb begin
        others  = request_i & ~grant_q;
        arb_req = (others != '0) ? others : request_i;
        rr_mask = '0;
        if (ARB_ROUND_ROBIN == ARB_RR) begin
            for (int i = 0; i < PORTS; i++) begin
                if (LSB_HIGH_PRIORITY != 0) begin
                    rr_mask[i] = (IW'(i) > ptr_q);
                end else begin
                    rr_mask[i] = (IW'(i) < ptr_q);
                end
            end
        end
    end

    arb_mask_encoder #(
        .PORTS (PORTS),
        .IW    (IW)
    ) u_pick (
        .request (arb_req),
        .mask    (rr_mask),
        .ascend  (LSB_HIGH_PRIORITY != 0),
        .valid   (pick_valid),
        .index   (pick_idx),
        .onehot  (pick_onehot)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CW = arb_idx_width(TIMEOUT_CYCLES);

    logic [CW-1:0] wd_cnt_q;

    assign wd_expire = (state_q == ARB_GRANTED) && !release_cond &&
                       (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Watchdog restarts with every new grant, including a re-grant of the
    // same port, and only advances while a grant is held.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_q <= '0;
        end else if (load_grant) begin
            wd_cnt_q <= '0;
        end else if (state_q == ARB_GRANTED) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    // Next-state logic. A release with other requests pending re-arbitrates
    // on the same edge so there is no idle bubble between grants.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        enc_d      = enc_q;
        ptr_d      = ptr_q;
        timeout_d  = 1'b0;
        load_grant = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    load_grant = 1'b1;
                    state_d    = ARB_GRANTED;
                end
            end
            ARB_GRANTED: begin
                if (release_cond || wd_expire) begin
                    timeout_d = wd_expire;
                    if (pick_valid) begin
                        load_grant = 1'b1;
                    end else begin
                        grant_d = '0;
                        enc_d   = '0;
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: begin
                grant_d = '0;
                enc_d   = '0;
                state_d = ARB_IDLE;
            end
        endcase
        if (load_grant) begin
            grant_d = pick_onehot;
            enc_d   = pick_idx;
            ptr_d   = pick_idx;
        end
    end

    // State, grant and pointer registers; all clear asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            enc_q     <= '0;
            ptr_q     <= PTR_RESET;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            enc_q     <= enc_d;
            ptr_q     <= ptr_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant_o         = grant_q;
    assign grant_valid_o   = |grant_q;
    assign grant_encoded_o = enc_q;
    assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter
// Directed scoreboard bench for wb_rr_arbiter. Four instances cover the
// round-robin/descending default, round-robin ascending non-blocking,
// fixed priority, and ack-release with an 8-cycle watchdog (active when
// ARB_TIMEOUT_EN is defined). Expectations are queued as stimulus is
// applied and popped once the registered outputs are due.
module tb_wb_rr_arbiter;

    typedef struct {
        string      tag;
        int         inst;
        logic [3:0] grant;
        logic       tmo;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req   [4];
    logic [3:0] ack   [4];
    logic [3:0] grant_w [4];
    logic       valid_w [4];
    logic [1:0] enc_w   [4];
    logic       tmo_w   [4];

    exp_t exp_q[$];
    int   tests_run;
    int   fail_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wb_rr_arbiter #(.PORTS(4), .ARB_ROUND_ROBIN(1), .LSB_HIGH_PRIORITY(0), .BLOCK(1), .BLOCK_ACK(0)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .request_i(req[0]), .acknowledge_i(ack[0]),
        .grant_o(grant_w[0]), .grant_valid_o(valid_w[0]), .grant_encoded_o(enc_w[0]), .timeout_o(tmo_w[0]));

    wb_rr_arbiter #(.PORTS(4), .ARB_ROUND_ROBIN(1), .LSB_HIGH_PRIORITY(1), .BLOCK(0), .BLOCK_ACK(0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .request_i(req[1]), .acknowledge_i(ack[1]),
        .grant_o(grant_w[1]), .grant_valid_o(valid_w[1]), .grant_encoded_o(enc_w[1]), .timeout_o(tmo_w[1]));

    wb_rr_arbiter #(.PORTS(4), .ARB_ROUND_ROBIN(0), .LSB_HIGH_PRIORITY(0), .BLOCK(1), .BLOCK_ACK(0)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .request_i(req[2]), .acknowledge_i(ack[2]),
        .grant_o(grant_w[2]), .grant_valid_o(valid_w[2]), .grant_encoded_o(enc_w[2]), .timeout_o(tmo_w[2]));

    wb_rr_arbiter #(.PORTS(4), .ARB_ROUND_ROBIN(1), .LSB_HIGH_PRIORITY(0), .BLOCK(1), .BLOCK_ACK(1),
                    .TIMEOUT_CYCLES(8)) dut_d (
        .clk_i(clk), .rst_ni(rst_n), .request_i(req[3]), .acknowledge_i(ack[3]),
        .grant_o(grant_w[3]), .grant_valid_o(valid_w[3]), .grant_encoded_o(enc_w[3]), .timeout_o(tmo_w[3]));

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Drive one instance's inputs and queue what it must show after the
    // next active edge.
    task automatic applyStimulus(input int inst, input logic [3:0] r, input logic [3:0] a,
                                 input string tag, input logic [3:0] exp_grant, input logic exp_tmo);
        exp_t e;
        req[inst] = r;
        ack[inst] = a;
        e.tag   = tag;
        e.inst  = inst;
        e.grant = exp_grant;
        e.tmo   = exp_tmo;
        exp_q.push_back(e);
    endtask

    // Optionally wait for the active edge, then drain the scoreboard.
    task automatic checkOutput(input bit wait_edge);
        exp_t e;
        if (wait_edge) begin
            @(posedge clk);
            #1;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            assert (grant_w[e.inst] === e.grant) else begin
                fail_count++;
                $error("[TB] FAIL %s grant got %b expected %b", e.tag, grant_w[e.inst], e.grant);
            end
            tests_run++;
            assert (valid_w[e.inst] === (|e.grant)) else begin
                fail_count++;
                $error("[TB] FAIL %s valid got %b expected %b", e.tag, valid_w[e.inst], |e.grant);
            end
            tests_run++;
            assert (enc_w[e.inst] === idx_of(e.grant)) else begin
                fail_count++;
                $error("[TB] FAIL %s encoded got %0d expected %0d", e.tag, enc_w[e.inst], idx_of(e.grant));
            end
            tests_run++;
            assert (tmo_w[e.inst] === e.tmo) else begin
                fail_count++;
                $error("[TB] FAIL %s timeout got %b expected %b", e.tag, tmo_w[e.inst], e.tmo);
            end
        end
    endtask

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    logic exp_t5;

    initial begin
        tests_run  = 0;
        fail_count = 0;
        rst_n      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req[i] = 4'b0000;
            ack[i] = 4'b0000;
        end
`ifdef ARB_TIMEOUT_EN
        exp_t5 = 1'b1;
`else
        exp_t5 = 1'b0;
`endif

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) applyStimulus(i, 4'b0000, 4'b0000, "reset", 4'b0000, 1'b0);
        checkOutput(0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-grant: grant port 2, then async reset clears at once.
        applyStimulus(0, 4'b0100, 4'b0000, "t1_grant", 4'b0100, 1'b0);
        checkOutput(1);
        applyStimulus(0, 4'b0100, 4'b0000, "t1_hold", 4'b0100, 1'b0);
        checkOutput(1);
        rst_n = 1'b0;
        applyStimulus(0, 4'b0100, 4'b0000, "t1_async_rst", 4'b0000, 1'b0);
        #1;
        checkOutput(0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 4'b0110, 4'b0000, "t1_ptr_reset", 4'b0100, 1'b0);
        checkOutput(1);

        // Idle: release to idle then ten empty cycles.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(0, 4'b0000, 4'b0000, "t6_idle", 4'b0000, 1'b0);
            checkOutput(1);
        end

        // Descending round-robin with blocking hold (pointer now 2).
        applyStimulus(0, 4'b1011, 4'b0000, "rr_desc_1", 4'b0010, 1'b0);
        checkOutput(1);
        applyStimulus(0, 4'b1001, 4'b0000, "rr_desc_0", 4'b0001, 1'b0);
        checkOutput(1);
        applyStimulus(0, 4'b1000, 4'b0000, "rr_desc_wrap", 4'b1000, 1'b0);
        checkOutput(1);
        applyStimulus(0, 4'b0000, 4'b0000, "rr_desc_idle", 4'b0000, 1'b0);
        checkOutput(1);

        // Ascending round-robin, re-arbitrating every cycle.
        applyStimulus(1, 4'b1111, 4'b0000, "t2_rr0", 4'b0001, 1'b0);
        checkOutput(1);
        applyStimulus(1, 4'b1111, 4'b0000, "t2_rr1", 4'b0010, 1'b0);
        checkOutput(1);
        applyStimulus(1, 4'b1111, 4'b0000, "t2_rr2", 4'b0100, 1'b0);
        checkOutput(1);
        applyStimulus(1, 4'b1111, 4'b0000, "t2_rr3", 4'b1000, 1'b0);
        checkOutput(1);
        applyStimulus(1, 4'b1111, 4'b0000, "t2_rr_wrap", 4'b0001, 1'b0);
        checkOutput(1);
        applyStimulus(1, 4'b0000, 4'b0000, "t2_idle", 4'b0000, 1'b0);
        checkOutput(1);

        // Fixed priority, MSB wins, back-to-back handover.
        applyStimulus(2, 4'b0101, 4'b0000, "t3_fixed2", 4'b0100, 1'b0);
        checkOutput(1);
        applyStimulus(2, 4'b0101, 4'b0000, "t3_hold", 4'b0100, 1'b0);
        checkOutput(1);
        applyStimulus(2, 4'b0001, 4'b0000, "t3_fixed0", 4'b0001, 1'b0);
        checkOutput(1);
        applyStimulus(2, 4'b0000, 4'b0000, "t3_idle", 4'b0000, 1'b0);
        checkOutput(1);

        // Ack release: ack on a non-granted port is ignored.
        applyStimulus(3, 4'b0011, 4'b0000, "t4_grant1", 4'b0010, 1'b0);
        checkOutput(1);
        applyStimulus(3, 4'b0011, 4'b0001, "t4_ack_other", 4'b0010, 1'b0);
        checkOutput(1);
        applyStimulus(3, 4'b0011, 4'b0010, "t4_ack_own", 4'b0001, 1'b0);
        checkOutput(1);
        applyStimulus(3, 4'b0011, 4'b0000, "t4_hold0", 4'b0001, 1'b0);
        checkOutput(1);
        applyStimulus(3, 4'b0000, 4'b0000, "t4_idle", 4'b0000, 1'b0);
        checkOutput(1);

        // Watchdog: port 3 hogs with port 1 waiting, then sole requester.
        applyStimulus(3, 4'b1000, 4'b0000, "t5_grant3", 4'b1000, 1'b0);
        checkOutput(1);
        for (int i = 1; i < 8; i++) begin
            applyStimulus(3, 4'b1010, 4'b0000, "t5_hold", 4'b1000, 1'b0);
            checkOutput(1);
        end
        applyStimulus(3, 4'b1010, 4'b0000, "t5_expire", exp_t5 ? 4'b0010 : 4'b1000, exp_t5);
        checkOutput(1);
        applyStimulus(3, 4'b1010, 4'b0000, "t5_after", exp_t5 ? 4'b0010 : 4'b1000, 1'b0);
        checkOutput(1);
        applyStimulus(3, 4'b1000, 4'b0000, "t5_back3", 4'b1000, 1'b0);
        checkOutput(1);
        for (int i = 1; i < 8; i++) begin
            applyStimulus(3, 4'b1000, 4'b0000, "t5_sole_hold", 4'b1000, 1'b0);
            checkOutput(1);
        end
        applyStimulus(3, 4'b1000, 4'b0000, "t5_sole_expire", 4'b1000, exp_t5);
        checkOutput(1);
        applyStimulus(3, 4'b1000, 4'b0000, "t5_sole_after", 4'b1000, 1'b0);
        checkOutput(1);
        applyStimulus(3, 4'b0000, 4'b0000, "t5_idle", 4'b0000, 1'b0);
        checkOutput(1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
